// File: rtl/cpu_run_pkg.sv
// Shared state encoding and status codes for the CPU run controller.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RESET_HOLD = 2'd1,
        RUN        = 2'd2,
        DONE       = 2'd3
    } run_state_e;

    localparam logic [1:0] ST_NONE    = 2'd0;
    localparam logic [1:0] ST_HALT    = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_STUCK   = 2'd3;

endpackage

// File: rtl/pc_stuck_det.sv
// Stuck-PC detector: tracks the last valid fetch PC and counts consecutive repeats.
// stuck is combinational so the controller can act on the same edge as the final repeat.
module pc_stuck_det #(
    parameter int unsigned PC_W         = 32,
    parameter int unsigned STUCK_CYCLES = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            clear,
    input  logic            enable,
    input  logic            pc_valid,
    input  logic [PC_W-1:0] pc_in,
    output logic            stuck
);

    localparam int unsigned SW = $clog2(STUCK_CYCLES + 1) + 1;
    localparam logic [SW:0] STUCK_LIM = (SW + 1)'(STUCK_CYCLES);

    logic [PC_W-1:0] last_pc_q, last_pc_d;
    logic [SW-1:0]   cnt_q, cnt_d;
    logic            same_pc;

    assign same_pc = pc_valid && (pc_in == last_pc_q);
    assign stuck   = (STUCK_CYCLES != 0) && enable && same_pc &&
                     ({1'b0, cnt_q} + 1'b1 == STUCK_LIM);

    always_comb begin
        last_pc_d = last_pc_q;
        cnt_d     = cnt_q;
        if (clear) begin
            last_pc_d = '0;
            cnt_d     = '0;
        end else if (enable && pc_valid) begin
            if (!same_pc) begin
                last_pc_d = pc_in;
                cnt_d     = '0;
            end else if (cnt_q != '1) begin
                // Saturate so a disabled detector never wraps.
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_pc_q <= '0;
            cnt_q     <= '0;
        end else begin
            last_pc_q <= last_pc_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run controller: sequences CPU reset, gates the CPU, counts run cycles and
// ends the run on halt, stuck PC or timeout, holding a status code.
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned RST_CYCLES   = 2,
    parameter int unsigned MAX_CYCLES   = 128,
    parameter int unsigned STUCK_CYCLES = 8,
    parameter int unsigned PC_W         = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             halt_req,
    input  logic             pc_valid,
    input  logic [PC_W-1:0]  pc_in,
    output logic             cpu_rst,
    output logic             cpu_en,
    output logic             running,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] cycle_count
);

    if (RST_CYCLES < 1 || (MAX_CYCLES >> CNT_W) != 0) begin : g_param_check
        $error("cpu_run_ctrl: RST_CYCLES must be >= 1 and MAX_CYCLES < 2**CNT_W");
    end

    localparam logic [CNT_W:0]   MAX_LIM   = (CNT_W + 1)'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_CYCLES - 1);

    run_state_e       state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d, count_inc;
    logic [1:0]       status_q, status_d;
    logic             cpu_rst_q, cpu_rst_d, cpu_en_q, cpu_en_d;
    logic             running_q, running_d, done_q, done_d;
    logic             run_clear, timeout, stuck;

    pc_stuck_det #(
        .PC_W         (PC_W),
        .STUCK_CYCLES (STUCK_CYCLES)
    ) u_stuck (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (run_clear),
        .enable   (state_q == RUN),
        .pc_valid (pc_valid),
        .pc_in    (pc_in),
        .stuck    (stuck)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        count_d   = count_q;
        status_d  = status_q;
        run_clear = 1'b0;
        count_inc = (count_q == '1) ? count_q : count_q + 1'b1;
        timeout   = (MAX_CYCLES != 0) && ({1'b0, count_q} + 1'b1 == MAX_LIM);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RESET_HOLD;
                    hold_d    = '0;
                    count_d   = '0;
                    status_d  = ST_NONE;
                    run_clear = 1'b1;
                end
            end
            RESET_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST) state_d = RUN;
            end
            RUN: begin
                // Exit cycle still counts as a run cycle.
                count_d = count_inc;
                if (halt_req) begin
                    state_d  = DONE;
                    status_d = ST_HALT;
                end else if (stuck) begin
                    state_d  = DONE;
                    status_d = ST_STUCK;
                end else if (timeout) begin
                    state_d  = DONE;
                    status_d = ST_TIMEOUT;
                end
            end
            default: state_d = IDLE;
        endcase

        cpu_rst_d = (state_d == IDLE) || (state_d == RESET_HOLD);
        cpu_en_d  = (state_d == RUN);
        running_d = (state_d == RUN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            count_q   <= '0;
            status_q  <= ST_NONE;
            cpu_rst_q <= 1'b1;
            cpu_en_q  <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            count_q   <= count_d;
            status_q  <= status_d;
            cpu_rst_q <= cpu_rst_d;
            cpu_en_q  <= cpu_en_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    assign cpu_rst     = cpu_rst_q;
    assign cpu_en      = cpu_en_q;
    assign running     = running_q;
    assign done        = done_q;
    assign status      = status_q;
    assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed and random runs checked against a run-level model,
// plus a second instance with timeout and stuck detection disabled.
module tb_cpu_run_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PC_W  = 32;
    localparam int unsigned MAX_C = 128;
    localparam int unsigned STK   = 8;
    localparam int unsigned NSTEP = 128;

    logic             CLK = 1'b0;
    logic             RST;
    logic             start, halt_req, pc_valid;
    logic [PC_W-1:0]  pc_in;
    logic             cpu_rst, cpu_en, running, done;
    logic [1:0]       status;
    logic [CNT_W-1:0] cycle_count;

    logic             start1, halt_req1, pc_valid1;
    logic [PC_W-1:0]  pc_in1;
    logic             cpu_rst1, cpu_en1, running1, done1;
    logic [1:0]       status1;
    logic [CNT_W-1:0] cycle_count1;

    int tests = 0;
    int fails = 0;

    bit          halt_v  [1:NSTEP];
    bit          val_v   [1:NSTEP];
    bit          start_v [1:NSTEP];
    logic [31:0] pc_v    [1:NSTEP];

    always #5 CLK = ~CLK;

    cpu_run_ctrl #(
        .CNT_W(CNT_W), .RST_CYCLES(2), .MAX_CYCLES(MAX_C), .STUCK_CYCLES(STK), .PC_W(PC_W)
    ) u_dut (
        .CLK(CLK), .RST(RST), .start(start), .halt_req(halt_req), .pc_valid(pc_valid),
        .pc_in(pc_in), .cpu_rst(cpu_rst), .cpu_en(cpu_en), .running(running), .done(done),
        .status(status), .cycle_count(cycle_count)
    );

    cpu_run_ctrl #(
        .CNT_W(CNT_W), .RST_CYCLES(2), .MAX_CYCLES(0), .STUCK_CYCLES(0), .PC_W(PC_W)
    ) u_dis (
        .CLK(CLK), .RST(RST), .start(start1), .halt_req(halt_req1), .pc_valid(pc_valid1),
        .pc_in(pc_in1), .cpu_rst(cpu_rst1), .cpu_en(cpu_en1), .running(running1),
        .done(done1), .status(status1), .cycle_count(cycle_count1)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stim();
        for (int k = 1; k <= NSTEP; k++) begin
            halt_v[k]  = 1'b0;
            val_v[k]   = 1'b1;
            start_v[k] = 1'b0;
            pc_v[k]    = 32'h1000 + 32'(4 * k);
        end
    endtask

    // Scan the run cycle by cycle and report on which RUN cycle it ends and why.
    function automatic void model(output int unsigned exit_k, output int unsigned exp_st);
        logic [31:0] last = '0;
        int unsigned reps = 0;
        exit_k = 0;
        exp_st = 0;
        for (int k = 1; k <= NSTEP; k++) begin
            bit          same;
            int unsigned st;
            same = val_v[k] && (pc_v[k] == last);
            st   = 0;
            if (halt_v[k])                  st = 1;
            else if (same && reps + 1 == STK) st = 3;
            else if (k == MAX_C)            st = 2;
            if (st != 0) begin
                exit_k = k;
                exp_st = st;
                return;
            end
            if (val_v[k]) begin
                if (same) reps++;
                else begin
                    last = pc_v[k];
                    reps = 0;
                end
            end
        end
    endfunction

    task automatic do_run(input string name);
        int unsigned ek, es;
        model(ek, es);
        // halt and PC activity outside RUN must be ignored
        start = 1'b1; halt_req = 1'b1; pc_valid = 1'b1; pc_in = 32'h40;
        tick();
        chk({name, "/hold1_rst"}, cpu_rst, 1);
        chk({name, "/hold1_en"}, cpu_en, 0);
        chk({name, "/hold1_done"}, done, 0);
        chk({name, "/hold1_status"}, status, 0);
        chk({name, "/hold1_cnt"}, cycle_count, 0);
        start = 1'b0;
        tick();
        chk({name, "/hold2_rst"}, cpu_rst, 1);
        chk({name, "/hold2_run"}, running, 0);
        tick();
        chk({name, "/run_rst"}, cpu_rst, 0);
        chk({name, "/run_en"}, cpu_en, 1);
        chk({name, "/run_running"}, running, 1);
        for (int k = 1; k <= int'(ek); k++) begin
            halt_req = halt_v[k];
            pc_valid = val_v[k];
            pc_in    = pc_v[k];
            start    = start_v[k];
            tick();
            chk({name, "/cnt"}, cycle_count, 64'(k));
            if (k < int'(ek)) chk({name, "/running"}, running, 1);
        end
        chk({name, "/done"}, done, 1);
        chk({name, "/status"}, status, 64'(es));
        chk({name, "/exit_en"}, cpu_en, 0);
        halt_req = 1'b0; pc_valid = 1'b0; start = 1'b0;
        tick();
        tick();
        chk({name, "/hold_done"}, done, 1);
        chk({name, "/hold_en"}, cpu_en, 0);
        chk({name, "/hold_rst"}, cpu_rst, 0);
        chk({name, "/hold_cnt"}, cycle_count, 64'(ek));
        chk({name, "/hold_status"}, status, 64'(es));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; start = 1'b0; halt_req = 1'b0; pc_valid = 1'b0; pc_in = '0;
        start1 = 1'b0; halt_req1 = 1'b0; pc_valid1 = 1'b0; pc_in1 = '0;
        tick();
        tick();
        chk("rst/cpu_rst", cpu_rst, 1);
        chk("rst/cpu_en", cpu_en, 0);
        chk("rst/running", running, 0);
        chk("rst/done", done, 0);
        chk("rst/status", status, 0);
        chk("rst/cnt", cycle_count, 0);
        chk("rst/dis_cpu_rst", cpu_rst1, 1);
        RST = 1'b0;
        tick();
        chk("idle/cpu_rst", cpu_rst, 1);
        chk("idle/running", running, 0);

        clear_stim();
        do_run("timeout");

        // restart from DONE with a mid-run start that must be ignored
        clear_stim();
        halt_v[10] = 1'b1;
        start_v[5] = 1'b1;
        do_run("halt");

        clear_stim();
        for (int k = 5; k <= NSTEP; k++) pc_v[k] = 32'h40;
        val_v[8] = 1'b0;
        do_run("stuck_gap");

        clear_stim();
        for (int k = 1; k <= NSTEP; k++) val_v[k] = (k >= 120);
        for (int k = 120; k <= NSTEP; k++) pc_v[k] = 32'h40;
        halt_v[128] = 1'b1;
        do_run("all_three");

        clear_stim();
        for (int k = 1; k <= NSTEP; k++) val_v[k] = (k >= 120);
        for (int k = 120; k <= NSTEP; k++) pc_v[k] = 32'h40;
        do_run("stuck_vs_timeout");

        clear_stim();
        for (int k = 1; k <= NSTEP; k++) pc_v[k] = '0;
        do_run("first_pc_zero");

        for (int r = 0; r < 6; r++) begin
            clear_stim();
            for (int k = 1; k <= NSTEP; k++) begin
                halt_v[k] = ($urandom_range(0, 149) == 0);
                val_v[k]  = ($urandom_range(0, 3) != 0);
                pc_v[k]   = 32'h200 + 32'(4 * $urandom_range(0, 1));
            end
            do_run("random");
        end

        // abort mid-run with RST
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        pc_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            pc_in = 32'h3000 + 32'(4 * k);
            tick();
        end
        chk("abort/pre_cnt", cycle_count, 5);
        RST = 1'b1;
        tick();
        chk("abort/cpu_rst", cpu_rst, 1);
        chk("abort/done", done, 0);
        chk("abort/running", running, 0);
        chk("abort/cpu_en", cpu_en, 0);
        chk("abort/status", status, 0);
        chk("abort/cnt", cycle_count, 0);
        RST = 1'b0;
        pc_valid = 1'b0;
        tick();
        clear_stim();
        do_run("after_abort");

        // disabled timeout and stuck detection with a constant PC
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        chk("dis/running", running1, 1);
        pc_valid1 = 1'b1;
        pc_in1    = 32'h40;
        for (int k = 1; k <= 300; k++) begin
            tick();
            if (k == 128) chk("dis/cnt128", cycle_count1, 128);
        end
        chk("dis/cnt300", cycle_count1, 300);
        chk("dis/running300", running1, 1);
        chk("dis/done", done1, 0);
        chk("dis/status", status1, 0);
        chk("dis/cpu_en", cpu_en1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
